// File: rtl/collision_pkg.sv
// Shared constants, type codes and FSM encoding for the collision map-port arbiter.
package collision_pkg;

  localparam int N_REQ     = 3;
  localparam int MAX_BURST = 4;
  localparam int IDX_W     = 2;
  localparam int CNT_W     = 3;

  localparam logic [IDX_W-1:0] REQ_PLAYER = 2'd0;
  localparam logic [IDX_W-1:0] REQ_BLADE  = 2'd1;
  localparam logic [IDX_W-1:0] REQ_LIZARD = 2'd2;

  typedef enum logic [2:0] {
    BLK_EMPTY    = 3'd0,
    BLK_SOLID    = 3'd1,
    BLK_PLATFORM = 3'd2,
    BLK_PASSABLE = 3'd3,
    BLK_LIZARD   = 3'd4
  } blockT;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arbStateT;

  // Successor of a requester index, wrapping at n.
  function automatic logic [IDX_W-1:0] wrapInc(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester found searching upward from rrPtr.
module rr_pick
  import collision_pkg::*;
#(
  parameter int N = N_REQ
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rrPtr,
  output logic [N-1:0]     oneHot,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] NW = (IDX_W+1)'(N);

  logic [2*N-1:0] reqDbl;
  logic [N-1:0]   rotated;
  logic [IDX_W:0] sum;

  // Rotate so rrPtr sits at bit 0; scanning downward lets the lowest offset win.
  always_comb begin
    reqDbl  = {req, req};
    rotated = reqDbl[rrPtr +: N];
    sum     = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        sum = {1'b0, rrPtr} + (IDX_W+1)'(k);
        idx = (sum >= NW) ? IDX_W'(sum - NW) : IDX_W'(sum);
      end
    end
    oneHot = (|rotated) ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/map_port_arbiter.sv
// Shares one tile-map read port between the collision resolvers with bursts,
// forced release after MAX_BURST grants, and a one-cycle in-order response path.
module map_port_arbiter #(
  parameter int N_REQ     = collision_pkg::N_REQ,
  parameter int MAX_BURST = collision_pkg::MAX_BURST
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     last,
  input  logic [10*N_REQ-1:0]  req_x,
  input  logic [10*N_REQ-1:0]  req_y,
  output logic [N_REQ-1:0]     gnt,
  output logic                 map_en,
  output logic [9:0]           map_x,
  output logic [9:0]           map_y,
  input  logic [2:0]           map_type,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [2:0]           rsp_type,
  output logic                 busy
);

  localparam int IW = collision_pkg::IDX_W;
  localparam int CW = collision_pkg::CNT_W;
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

  collision_pkg::arbStateT state, stateNext;
  logic [IW-1:0]    owner, ownerNext;
  logic [IW-1:0]    rrPtr, rrPtrNext;
  logic [CW-1:0]    burstCnt, burstCntNext;
  logic             tagValid;
  logic [IW-1:0]    tag;
  logic [N_REQ-1:0] pickGnt;
  logic [IW-1:0]    pickIdx;
  logic [N_REQ-1:0] gntInt;
  logic [IW-1:0]    grantIdx;

  rr_pick #(.N(N_REQ)) uPick (
    .req    (req),
    .rrPtr  (rrPtr),
    .oneHot (pickGnt),
    .idx    (pickIdx)
  );

  // IDLE grants from the round-robin picker in the same cycle; OWNED streams to the owner
  // and releases on last, on hitting the burst limit, or when the owner drops req.
  always_comb begin
    stateNext    = state;
    ownerNext    = owner;
    rrPtrNext    = rrPtr;
    burstCntNext = burstCnt;
    gntInt       = '0;
    grantIdx     = '0;
    case (state)
      collision_pkg::IDLE: begin
        if (|pickGnt) begin
          gntInt   = pickGnt;
          grantIdx = pickIdx;
          if (last[pickIdx] || BURST_LIMIT == CW'(1)) begin
            rrPtrNext = collision_pkg::wrapInc(pickIdx, N_REQ);
          end else begin
            stateNext    = collision_pkg::OWNED;
            ownerNext    = pickIdx;
            burstCntNext = CW'(1);
          end
        end
      end
      collision_pkg::OWNED: begin
        grantIdx = owner;
        if (req[owner]) begin
          gntInt[owner] = 1'b1;
          burstCntNext  = burstCnt + 1'b1;
          if (last[owner] || (burstCnt + 1'b1) == BURST_LIMIT) begin
            stateNext = collision_pkg::IDLE;
            rrPtrNext = collision_pkg::wrapInc(owner, N_REQ);
          end
        end else begin
          stateNext = collision_pkg::IDLE;
          rrPtrNext = collision_pkg::wrapInc(owner, N_REQ);
        end
      end
      default: stateNext = collision_pkg::IDLE;
    endcase
  end

  assign gnt       = rst_n ? gntInt : '0;
  assign map_en    = |gnt;
  assign map_x     = map_en ? req_x[grantIdx*10 +: 10] : '0;
  assign map_y     = map_en ? req_y[grantIdx*10 +: 10] : '0;
  assign rsp_valid = tagValid ? (N_REQ'(1) << tag) : '0;
  assign rsp_type  = tagValid ? map_type : '0;
  assign busy      = (state == collision_pkg::OWNED) || tagValid;

  // Reset drops any outstanding response tag along with arbitration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= collision_pkg::IDLE;
      owner    <= '0;
      rrPtr    <= '0;
      burstCnt <= '0;
      tagValid <= 1'b0;
      tag      <= '0;
    end else begin
      state    <= stateNext;
      owner    <= ownerNext;
      rrPtr    <= rrPtrNext;
      burstCnt <= burstCntNext;
      tagValid <= map_en;
      if (map_en) tag <= grantIdx;
    end
  end

endmodule
